// File: rtl/axi_lite_slave_regs.sv
// ----------------------------------------------------------------------------
// axi_lite_slave_regs
//
// AXI4-Lite slave register bank for the DMA controller control/status space.
// NUM_REGS registers of DATA_WIDTH bits. Each register is either read-write
// (stored here, merged byte-wise under WSTRB) or read-only (RO_MASK bit set;
// reads return the matching ro_in slice, writes are refused with SLVERR).
// AW and W are captured independently, in any order, and one write commits
// as soon as both are present. Only one write response is outstanding at a
// time. The read path runs fully independently of the write path.
//
// Ports
//   ACLK, ARESETN            clock, asynchronous active-low reset
//   AWADDR/AWVALID/AWREADY   write address channel
//   WDATA/WSTRB/WVALID/WREADY write data channel
//   BRESP/BVALID/BREADY      write response channel
//   ARADDR/ARVALID/ARREADY   read address channel
//   RDATA/RRESP/RVALID/RREADY read data channel
//   reg_out   stored RW register values, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//             (RO registers read as 0 here)
//   ro_in     status values returned for RO registers, same packing
//   wr_pulse  one-cycle strobe per successful register write
// ----------------------------------------------------------------------------
module axi_lite_slave_regs #(
    parameter int                   ADDR_WIDTH = 32,
    parameter int                   DATA_WIDTH = 32,
    parameter int                   NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,

    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,

    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,

    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,

    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,

    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,

    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int         STRB_W      = DATA_WIDTH / 8;
    localparam int         LSB         = $clog2(STRB_W);
    localparam int         IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte-offset bits are dropped; every remaining upper bit takes part in
    // the range check so aliases above the bank are rejected.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word;
        word = addr >> LSB;
        return word < ADDR_WIDTH'(NUM_REGS);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word;
        word = addr >> LSB;
        return word[IDX_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Write channel capture and commit
    // ------------------------------------------------------------------
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [IDX_W-1:0]      wr_idx;
    logic                  wr_ok;

    assign AWREADY = !aw_held && !BVALID;
    assign WREADY  = !w_held  && !BVALID;
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID  && WREADY;

    // NOTE: every signal driven here gets a default at the top of the block,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_addr = aw_held ? aw_addr_q : AWADDR;
        wr_data = w_held  ? w_data_q  : WDATA;
        wr_strb = w_held  ? w_strb_q  : WSTRB;
        // Commit on the edge where the second half arrives, or both arrive.
        commit  = (aw_held || aw_hs) && (w_held || w_hs);
        wr_idx  = addr_idx(wr_addr);
        wr_ok   = addr_in_range(wr_addr) && !RO_MASK[wr_idx];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            BVALID    <= 1'b0;
            BRESP     <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                BVALID  <= 1'b1;
                BRESP   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= AWADDR;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= WDATA;
                    w_strb_q <= WSTRB;
                end
                if (BVALID && BREADY) begin
                    BVALID <= 1'b0;
                    BRESP  <= RESP_OKAY;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Register bank
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // NOTE: the bank must come out of reset as all zeros, so it is built from
    // resettable flops rather than an inferred RAM.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit && wr_ok) begin
                wr_pulse[wr_idx] <= 1'b1;
                for (int b = 0; b < STRB_W; b++) begin
                    if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // RO registers are never written, so their storage stays at zero.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic                  ar_hs;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] rd_word;

    assign ARREADY = !RVALID;
    assign ar_hs   = ARVALID && ARREADY;

    always_comb begin
        rd_idx      = addr_idx(ARADDR);
        rd_in_range = addr_in_range(ARADDR);
        rd_word     = '0;
        if (rd_in_range) begin
            rd_word = RO_MASK[rd_idx] ? ro_in[int'(rd_idx)*DATA_WIDTH +: DATA_WIDTH]
                                      : regs[rd_idx];
        end
    end

    // A read and a write commit to the same register on one edge return the
    // old value, since regs updates on that same edge.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
            RRESP  <= RESP_OKAY;
        end else if (ar_hs) begin
            RVALID <= 1'b1;
            RDATA  <= rd_word;
            RRESP  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (RVALID && RREADY) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
            RRESP  <= RESP_OKAY;
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_slave_regs
//
// Self-checking bench for axi_lite_slave_regs (32-bit data, 16 registers,
// registers 5 and 12 read-only). A table of directed transactions is run
// first, then hand-written multi-cycle sequences (split AW/W order, response
// back-pressure, same-cycle read/write, reset mid-transaction), then random
// traffic checked against an array-based reference model.
// ----------------------------------------------------------------------------
module tb_axi_lite_slave_regs;

    localparam int          AW = 32;
    localparam int          DW = 32;
    localparam int          NR = 16;
    localparam logic [NR-1:0] RO = 16'h1020;

    logic               ACLK;
    logic               ARESETN;
    logic [AW-1:0]      AWADDR;
    logic               AWVALID;
    logic               AWREADY;
    logic [DW-1:0]      WDATA;
    logic [DW/8-1:0]    WSTRB;
    logic               WVALID;
    logic               WREADY;
    logic [1:0]         BRESP;
    logic               BVALID;
    logic               BREADY;
    logic [AW-1:0]      ARADDR;
    logic               ARVALID;
    logic               ARREADY;
    logic [DW-1:0]      RDATA;
    logic [1:0]         RRESP;
    logic               RVALID;
    logic               RREADY;
    logic [NR*DW-1:0]   reg_out;
    logic [NR*DW-1:0]   ro_in;
    logic [NR-1:0]      wr_pulse;

    axi_lite_slave_regs #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_out(reg_out), .ro_in(ro_in), .wr_pulse(wr_pulse)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] ro_vals    [NR];
    logic [31:0] model_regs [NR];
    int          pulse_cnt  [NR];

    always_comb begin
        ro_in = '0;
        for (int i = 0; i < NR; i++) ro_in[i*32 +: 32] = ro_vals[i];
    end

    initial for (int i = 0; i < NR; i++) pulse_cnt[i] = 0;
    always @(negedge ACLK) begin
        for (int i = 0; i < NR; i++) if (wr_pulse[i]) pulse_cnt[i]++;
    end

    task automatic check(input string name, input logic [NR*DW-1:0] act,
                         input logic [NR*DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int pulse_total();
        int s = 0;
        for (int i = 0; i < NR; i++) s += pulse_cnt[i];
        return s;
    endfunction

    // Reference model: a word-addressed array with byte merging.
    function automatic logic [1:0] model_write(input logic [31:0] addr,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
        logic [31:0] idx = addr >> 2;
        if (idx >= NR || RO[idx[3:0]]) return 2'b10;
        for (int b = 0; b < 4; b++)
            if (strb[b]) model_regs[idx[3:0]][8*b +: 8] = data[8*b +: 8];
        return 2'b00;
    endfunction

    function automatic void model_read(input logic [31:0] addr,
                                       output logic [31:0] data,
                                       output logic [1:0]  resp);
        logic [31:0] idx = addr >> 2;
        if (idx >= NR) begin
            data = 32'h0; resp = 2'b10;
        end else begin
            data = RO[idx[3:0]] ? ro_vals[idx[3:0]] : model_regs[idx[3:0]];
            resp = 2'b00;
        end
    endfunction

    function automatic logic [NR*DW-1:0] model_pack();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*32 +: 32] = model_regs[i];
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Bus tasks: all start and end 1 time unit after a rising edge.
    // ------------------------------------------------------------------
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly,
                            input int w_dly, input int b_dly,
                            output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_f, w_f;
        int cyc = 0;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        while (!(aw_done && w_done)) begin
            AWVALID = !aw_done && (cyc >= aw_dly);
            WVALID  = !w_done  && (cyc >= w_dly);
            #3;
            aw_f = AWVALID && AWREADY;
            w_f  = WVALID  && WREADY;
            if (w_done && !aw_done) check("wready_while_held", WREADY, 0);
            if (aw_done && !w_done) check("awready_while_held", AWREADY, 0);
            @(posedge ACLK); #1;
            aw_done |= aw_f; w_done |= w_f; cyc++;
            if (cyc > 40) begin
                check("write_handshake_timeout", 0, 1);
                break;
            end
        end
        AWVALID = 0; WVALID = 0;
        check("bvalid_latency", BVALID, 1);
        resp = BRESP;
        for (int k = 0; k < b_dly; k++) begin
            @(posedge ACLK); #1;
            check("b_hold", {BVALID, BRESP, AWREADY, WREADY}, {1'b1, resp, 2'b00});
        end
        BREADY = 1;
        @(posedge ACLK); #1;
        BREADY = 0;
        check("bvalid_clear", BVALID, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp);
        bit fire;
        int cyc = 0;
        ARADDR = addr; ARVALID = 1;
        forever begin
            #3; fire = ARREADY;
            @(posedge ACLK); #1;
            if (fire) break;
            if (++cyc > 40) begin
                check("read_handshake_timeout", 0, 1);
                break;
            end
        end
        ARVALID = 0;
        check("rvalid_latency", RVALID, 1);
        data = RDATA; resp = RRESP;
        for (int k = 0; k < r_dly; k++) begin
            @(posedge ACLK); #1;
            check("r_hold", {RVALID, RDATA, RRESP, ARREADY}, {1'b1, data, resp, 1'b0});
        end
        RREADY = 1;
        @(posedge ACLK); #1;
        RREADY = 0;
        check("rvalid_clear", RVALID, 0);
    endtask

    // Write with response, pulse and register checks. The model must already
    // hold the post-write state when this is called.
    task automatic run_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly,
                             input int w_dly, input int b_dly,
                             input logic [1:0] exp_resp, input logic [31:0] exp_reg);
        int          idx = int'(addr[5:2]);
        int          t0  = pulse_total();
        int          i0  = pulse_cnt[idx];
        logic [1:0]  resp;
        do_write(addr, data, strb, aw_dly, w_dly, b_dly, resp);
        check("bresp", resp, exp_resp);
        check("pulse_total", pulse_total() - t0, (exp_resp == 2'b00) ? 1 : 0);
        if (exp_resp == 2'b00) begin
            check("pulse_idx", pulse_cnt[idx] - i0, 1);
            check("reg_value", reg_out[idx*32 +: 32], exp_reg);
        end
        check("reg_out_all", reg_out, model_pack());
    endtask

    task automatic run_read(input logic [31:0] addr, input int r_dly,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        do_read(addr, r_dly, d, r);
        check("rdata", d, exp_data);
        check("rresp", r, exp_resp);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;   // read: RDATA; write: register value afterwards
        logic [1:0]  exp_resp;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    initial begin
        logic [1:0]  er;
        logic [31:0] ed, a, d;
        logic [3:0]  s;
        int          idx;

        vecs[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 2'b00};
        vecs[1]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
        vecs[2]  = '{1'b1, 32'h0C, 32'hAABBCCDD, 4'hF, 32'hAABBCCDD, 2'b00};
        vecs[3]  = '{1'b1, 32'h0C, 32'h00000011, 4'h1, 32'hAABBCC11, 2'b00};
        vecs[4]  = '{1'b0, 32'h0C, 32'h0,        4'h0, 32'hAABBCC11, 2'b00};
        vecs[5]  = '{1'b1, 32'h14, 32'h12345678, 4'hF, 32'h0,        2'b10};
        vecs[6]  = '{1'b0, 32'h14, 32'h0,        4'h0, 32'h0000CAFE, 2'b00};
        vecs[7]  = '{1'b0, 32'h40, 32'h0,        4'h0, 32'h0,        2'b10};
        vecs[8]  = '{1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10};
        vecs[9]  = '{1'b1, 32'h0A, 32'h00FF0000, 4'h4, 32'hDEFFBEEF, 2'b00};
        vecs[10] = '{1'b0, 32'h0B, 32'h0,        4'h0, 32'hDEFFBEEF, 2'b00};
        vecs[11] = '{1'b1, 32'h08, 32'h01020304, 4'h0, 32'hDEFFBEEF, 2'b00};
        vecs[12] = '{1'b1, 32'h80000008, 32'hCAFEF00D, 4'hF, 32'h0,  2'b10};
        vecs[13] = '{1'b0, 32'h80000008, 32'h0,  4'h0, 32'h0,        2'b10};
        vecs[14] = '{1'b0, 32'h30, 32'h0,        4'h0, 32'h1234ABCD, 2'b00};
        vecs[15] = '{1'b1, 32'h3C, 32'h5A5A5A5A, 4'h6, 32'h005A5A00, 2'b00};
        vecs[16] = '{1'b0, 32'h3C, 32'h0,        4'h0, 32'h005A5A00, 2'b00};

        for (int i = 0; i < NR; i++) begin
            ro_vals[i]    = $urandom;
            model_regs[i] = 32'h0;
        end
        ro_vals[5]  = 32'h0000CAFE;
        ro_vals[12] = 32'h1234ABCD;

        ARESETN = 0; AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0;
        BREADY = 0; ARADDR = 0; ARVALID = 0; RREADY = 0;

        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        check("reset_outputs", {BVALID, RVALID, BRESP, RRESP, RDATA, wr_pulse}, '0);
        check("reset_regs", reg_out, '0);
        #3 ARESETN = 1;
        @(posedge ACLK); #1;
        check("ready_after_reset", {AWREADY, WREADY, ARREADY}, 3'b111);

        // Table
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr) begin
                void'(model_write(vecs[i].addr, vecs[i].data, vecs[i].strb));
                run_write(vecs[i].addr, vecs[i].data, vecs[i].strb,
                          (i % 4 == 1) ? 2 : 0, (i % 4 == 2) ? 2 : 0, i % 2,
                          vecs[i].exp_resp, vecs[i].exp_data);
            end else begin
                run_read(vecs[i].addr, i % 2, vecs[i].exp_data, vecs[i].exp_resp);
            end
        end

        // W first, AW three cycles later; then the opposite order
        void'(model_write(32'h04, 32'h11223344, 4'hF));
        run_write(32'h04, 32'h11223344, 4'hF, 3, 0, 0, 2'b00, 32'h11223344);
        void'(model_write(32'h04, 32'h0, 4'hF));
        run_write(32'h04, 32'h0, 4'hF, 0, 0, 0, 2'b00, 32'h0);
        void'(model_write(32'h04, 32'h11223344, 4'hF));
        run_write(32'h04, 32'h11223344, 4'hF, 0, 3, 0, 2'b00, 32'h11223344);

        // Response back-pressure for five cycles on both channels
        void'(model_write(32'h18, 32'h0F0F0F0F, 4'hF));
        run_write(32'h18, 32'h0F0F0F0F, 4'hF, 0, 0, 5, 2'b00, 32'h0F0F0F0F);
        run_read(32'h18, 5, 32'h0F0F0F0F, 2'b00);

        // Same-cycle read and write commit to register 7: read sees old value
        void'(model_write(32'h1C, 32'h0BADF00D, 4'hF));
        run_write(32'h1C, 32'h0BADF00D, 4'hF, 0, 0, 0, 2'b00, 32'h0BADF00D);
        AWADDR = 32'h1C; WDATA = 32'h600DCAFE; WSTRB = 4'hF; ARADDR = 32'h1C;
        AWVALID = 1; WVALID = 1; ARVALID = 1;
        #3 check("simul_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        check("simul_rdata", {RVALID, RDATA, RRESP}, {1'b1, 32'h0BADF00D, 2'b00});
        check("simul_bresp", {BVALID, BRESP}, {1'b1, 2'b00});
        check("simul_reg", reg_out[7*32 +: 32], 32'h600DCAFE);
        BREADY = 1; RREADY = 1;
        @(posedge ACLK); #1;
        BREADY = 0; RREADY = 0;
        void'(model_write(32'h1C, 32'h600DCAFE, 4'hF));

        // Reset while only AW is held
        AWADDR = 32'h08; AWVALID = 1;
        @(posedge ACLK); #1;
        AWVALID = 0;
        check("aw_held_ready", {AWREADY, WREADY}, 2'b01);
        #2 ARESETN = 0;
        #1 check("async_reset_regs", reg_out, '0);
        check("async_reset_ready", {AWREADY, BVALID}, 2'b10);
        @(posedge ACLK);
        #3 ARESETN = 1;
        for (int i = 0; i < NR; i++) model_regs[i] = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(posedge ACLK); #1;
            check("post_reset_idle", {BVALID, AWREADY, WREADY, ARREADY}, 4'b0111);
        end
        check("post_reset_regs", reg_out, '0);
        // A lone W must now wait for a fresh AW rather than pair with the old one
        WDATA = 32'hA5A5A5A5; WSTRB = 4'hF; WVALID = 1;
        @(posedge ACLK); #1;
        WVALID = 0;
        @(posedge ACLK); #1;
        check("no_stale_commit", {BVALID, WREADY}, 2'b00);
        AWADDR = 32'h10; AWVALID = 1;
        @(posedge ACLK); #1;
        AWVALID = 0;
        check("late_aw_commit", {BVALID, BRESP}, {1'b1, 2'b00});
        BREADY = 1;
        @(posedge ACLK); #1;
        BREADY = 0;
        void'(model_write(32'h10, 32'hA5A5A5A5, 4'hF));
        check("late_aw_regs", reg_out, model_pack());

        // Random traffic against the model
        for (int n = 0; n < 150; n++) begin
            idx = $urandom_range(0, 19);
            a   = 32'(idx * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a[31] = 1'b1;
            if ($urandom_range(0, 9) == 0) ro_vals[$urandom_range(0, NR-1)] = $urandom;
            if ($urandom_range(0, 9) < 6) begin
                d  = $urandom;
                s  = 4'($urandom);
                er = model_write(a, d, s);
                run_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2),
                          $urandom_range(0, 2), er, model_regs[a[5:2]]);
            end else begin
                model_read(a, ed, er);
                run_read(a, $urandom_range(0, 2), ed, er);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
